// File: rtl/alu_div_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_sequencer_if
//  Purpose  : Divide request/result handshake plus the shared-ALU port bundle
//             driven by the divide sequencer while it is busy.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif
`ifndef ALUOp_SELA
`define ALUOp_SELA 0
`endif
`ifndef ALUOp_SUB
`define ALUOp_SUB 3
`endif
`ifndef CF_IDX
`define CF_IDX 0
`endif

interface alu_div_sequencer_if;
    // request side
    logic                          start;
    logic                          is_8_bit;
    logic [31:0]                   dividend;
    logic [15:0]                   divisor;
    logic                          busy;
    logic                          complete;
    logic                          error;
    logic [15:0]                   quotient;
    logic [15:0]                   remainder;
    // shared ALU side
    logic [15:0]                   alu_a;
    logic [15:0]                   alu_b;
    logic [`MC_ALUOp_t_BITS-1:0]   alu_op;
    logic                          alu_is_8_bit;
    logic [15:0]                   alu_out;
    logic [15:0]                   alu_flags;

    modport slave (
        input  start, is_8_bit, dividend, divisor, alu_out, alu_flags,
        output busy, complete, error, quotient, remainder,
               alu_a, alu_b, alu_op, alu_is_8_bit
    );

    modport master (
        output start, is_8_bit, dividend, divisor, alu_out, alu_flags,
        input  busy, complete, error, quotient, remainder,
               alu_a, alu_b, alu_op, alu_is_8_bit
    );
endinterface

`default_nettype wire

// File: rtl/alu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_sequencer
//  Purpose  : Unsigned 32/16 and 16/8 restoring divider that borrows the
//             shared ALU for one subtract per quotient bit.
//  Revision : 1.0  initial release
// ============================================================================

module alu_div_sequencer (
    input  wire logic           clk,
    input  wire logic           reset,
    alu_div_sequencer_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_iter  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [`MC_ALUOp_t_BITS-1:0] c_op_sela = `MC_ALUOp_t_BITS'(`ALUOp_SELA);
    localparam logic [`MC_ALUOp_t_BITS-1:0] c_op_sub  = `MC_ALUOp_t_BITS'(`ALUOp_SUB);

    logic [1:0]                  r_state;
    logic                        r_is_8_bit;
    logic [15:0]                 r_divisor;
    logic [15:0]                 r_rem;
    logic [15:0]                 r_quo;
    logic [4:0]                  r_count;
    logic [15:0]                 r_quotient;
    logic [15:0]                 r_remainder;
    logic                        r_error;

    logic [1:0]                  w_state_next;
    logic [15:0]                 w_alu_a;
    logic [15:0]                 w_alu_b;
    logic [`MC_ALUOp_t_BITS-1:0] w_alu_op;
    logic                        w_carry;
    logic                        w_q_msb;
    logic                        w_shift_out;
    logic [15:0]                 w_rem_shift;
    logic                        w_accept;
    logic [15:0]                 w_rem_next;
    logic [15:0]                 w_quo_next;
    logic [15:0]                 w_start_high;
    logic [15:0]                 w_start_low;
    logic [15:0]                 w_start_div;
    logic                        w_unused_flags;

    // Only the carry (borrow) flag matters; the rest of flags_out is ignored.
    assign w_carry        = bus.alu_flags[`CF_IDX];
    assign w_unused_flags = ^bus.alu_flags;

    always_comb begin
        w_start_high = bus.is_8_bit ? {8'h00, bus.dividend[15:8]} : bus.dividend[31:16];
        w_start_low  = bus.is_8_bit ? {8'h00, bus.dividend[7:0]}  : bus.dividend[15:0];
        w_start_div  = bus.is_8_bit ? {8'h00, bus.divisor[7:0]}   : bus.divisor;
    end

    // One restoring step: shift the next dividend bit into R, then keep the
    // ALU difference when it is non-negative or when R overflowed its width.
    always_comb begin
        w_q_msb     = r_is_8_bit ? r_quo[7] : r_quo[15];
        w_shift_out = r_is_8_bit ? r_rem[7] : r_rem[15];
        w_rem_shift = r_is_8_bit ? {8'h00, r_rem[6:0], w_q_msb} : {r_rem[14:0], w_q_msb};
        w_accept    = w_shift_out | ~w_carry;
        if (w_accept) begin
            w_rem_next = r_is_8_bit ? {8'h00, bus.alu_out[7:0]} : bus.alu_out;
        end else begin
            w_rem_next = w_rem_shift;
        end
        w_quo_next  = r_is_8_bit ? {8'h00, r_quo[6:0], w_accept} : {r_quo[14:0], w_accept};
    end

    always_comb begin
        w_state_next = r_state;
        w_alu_a      = 16'h0000;
        w_alu_b      = 16'h0000;
        w_alu_op     = c_op_sela;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_state_next = c_st_check;
                end
            end
            c_st_check: begin
                w_alu_a      = r_rem;
                w_alu_b      = r_divisor;
                w_alu_op     = c_op_sub;
                w_state_next = w_carry ? c_st_iter : c_st_done;
            end
            c_st_iter: begin
                w_alu_a  = w_rem_shift;
                w_alu_b  = r_divisor;
                w_alu_op = c_op_sub;
                if (r_count == 5'd1) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Results are written on the edge entering DONE so they are already valid
    // while complete is high, and then simply hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_8_bit  <= 1'b0;
            r_divisor   <= 16'h0000;
            r_rem       <= 16'h0000;
            r_quo       <= 16'h0000;
            r_count     <= 5'd0;
            r_quotient  <= 16'h0000;
            r_remainder <= 16'h0000;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_is_8_bit <= bus.is_8_bit;
                        r_divisor  <= w_start_div;
                        r_rem      <= w_start_high;
                        r_quo      <= w_start_low;
                        r_count    <= bus.is_8_bit ? 5'd8 : 5'd16;
                    end
                end
                c_st_check: begin
                    if (!w_carry) begin
                        r_error <= 1'b1;
                    end
                end
                c_st_iter: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next;
                        r_error     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy         = (r_state != c_st_idle);
    assign bus.complete     = (r_state == c_st_done);
    assign bus.error        = r_error;
    assign bus.quotient     = r_quotient;
    assign bus.remainder    = r_remainder;
    assign bus.alu_a        = w_alu_a;
    assign bus.alu_b        = w_alu_b;
    assign bus.alu_op       = w_alu_op;
    assign bus.alu_is_8_bit = r_is_8_bit;

endmodule

`default_nettype wire

// File: tb/tb_alu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_div_sequencer
//  Purpose  : Directed bench for alu_div_sequencer with a behavioural ALU.
//  Revision : 1.0  initial release
// ============================================================================

module tb_alu_div_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_div_sequencer_if bus ();

    alu_div_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational ALU: SUB sets CF on borrow at the selected width.
    logic [8:0]  d8;
    logic [16:0] d16;
    always_comb begin
        d8            = {1'b0, bus.alu_a[7:0]} - {1'b0, bus.alu_b[7:0]};
        d16           = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_out   = bus.alu_a;
        bus.alu_flags = 16'h0000;
        if (bus.alu_op == `MC_ALUOp_t_BITS'(`ALUOp_SUB)) begin
            if (bus.alu_is_8_bit) begin
                bus.alu_out             = {8'h00, d8[7:0]};
                bus.alu_flags[`CF_IDX]  = d8[8];
            end else begin
                bus.alu_out             = d16[15:0];
                bus.alu_flags[`CF_IDX]  = d16[16];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"},         32'(bus.busy),         32'(1'b0));
        check({tag, " complete"},     32'(bus.complete),     32'(1'b0));
        check({tag, " error"},        32'(bus.error),        32'(1'b0));
        check({tag, " quotient"},     32'(bus.quotient),     32'h0);
        check({tag, " remainder"},    32'(bus.remainder),    32'h0);
        check({tag, " alu_a"},        32'(bus.alu_a),        32'h0);
        check({tag, " alu_b"},        32'(bus.alu_b),        32'h0);
        check({tag, " alu_op"},       32'(bus.alu_op),       32'(`ALUOp_SELA));
        check({tag, " alu_is_8_bit"}, 32'(bus.alu_is_8_bit), 32'(1'b0));
    endtask

    // Entered and left at a negedge of an IDLE cycle; start is raised in that
    // cycle, so consecutive calls exercise back-to-back operation.
    task automatic run_op(input string name, input logic is8, input logic [31:0] dvd,
                          input logic [15:0] dvs, input logic exp_err,
                          input logic [15:0] exp_q, input logic [15:0] exp_r,
                          input bit disturb);
        int          n_done;
        logic [15:0] exp_h;
        logic [15:0] exp_d;
        n_done = exp_err ? 2 : (is8 ? 10 : 18);
        exp_h  = is8 ? {8'h00, dvd[15:8]} : dvd[31:16];
        exp_d  = is8 ? {8'h00, dvs[7:0]}  : dvs;
        bus.start    = 1'b1;
        bus.is_8_bit = is8;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        for (int c = 1; c <= n_done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start    = 1'b0;
                bus.is_8_bit = ~is8;
                bus.dividend = ~dvd;
                bus.divisor  = ~dvs;
                check({name, " check alu_op"}, 32'(bus.alu_op), 32'(`ALUOp_SUB));
                check({name, " check alu_a"},  32'(bus.alu_a),  32'(exp_h));
                check({name, " check alu_b"},  32'(bus.alu_b),  32'(exp_d));
                check({name, " alu_is_8_bit"}, 32'(bus.alu_is_8_bit), 32'(is8));
            end
            if (disturb && c == 3) begin
                bus.start    = 1'b1;
                bus.is_8_bit = 1'b0;
                bus.dividend = 32'h0001_0000;
                bus.divisor  = 16'h0003;
            end
            if (disturb && c == 4) begin
                bus.start = 1'b0;
            end
            check($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'(1'b1));
            check($sformatf("%s complete c%0d", name, c), 32'(bus.complete), 32'(c == n_done));
            if (is8) begin
                check($sformatf("%s alu_a hi c%0d", name, c), 32'(bus.alu_a[15:8]), 32'h0);
                check($sformatf("%s alu_b hi c%0d", name, c), 32'(bus.alu_b[15:8]), 32'h0);
            end
        end
        check({name, " error"},     32'(bus.error),     32'(exp_err));
        check({name, " quotient"},  32'(bus.quotient),  32'(exp_q));
        check({name, " remainder"}, 32'(bus.remainder), 32'(exp_r));
        @(negedge clk);
        check({name, " idle busy"},     32'(bus.busy),     32'(1'b0));
        check({name, " idle complete"}, 32'(bus.complete), 32'(1'b0));
        check({name, " idle alu_op"},   32'(bus.alu_op),   32'(`ALUOp_SELA));
        check({name, " idle alu_a"},    32'(bus.alu_a),    32'h0);
        check({name, " hold quotient"}, 32'(bus.quotient), 32'(exp_q));
        check({name, " hold error"},    32'(bus.error),    32'(exp_err));
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.is_8_bit = 1'b0;
        bus.dividend = 32'h0;
        bus.divisor  = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", 32'(bus.busy), 32'(1'b0));

        run_op("div16",      1'b0, 32'h0001_0000, 16'h0003, 1'b0, 16'h5555, 16'h0001, 1'b0);
        run_op("div8",       1'b1, 32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0);
        run_op("shiftout",   1'b0, 32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("divzero",    1'b0, 32'h1234_5678, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("overflow",   1'b0, 32'h0003_0000, 16'h0003, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("div8zero",   1'b1, 32'h0000_0064, 16'h0100, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("busystart",  1'b1, 32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b1);
        run_op("div16mixed", 1'b0, 32'h1234_5678, 16'h4321, 1'b0, 16'h456C, 16'h1F8C, 1'b0);

        // Abort a 16-bit divide with reset during cycle 5.
        bus.start    = 1'b1;
        bus.is_8_bit = 1'b0;
        bus.dividend = 32'h0001_0000;
        bus.divisor  = 16'h0003;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("abort complete c%0d", c), 32'(bus.complete), 32'(1'b0));
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort idle complete", 32'(bus.complete), 32'(1'b0));
        check("abort idle busy",     32'(bus.busy),     32'(1'b0));

        run_op("afterreset", 1'b1, 32'hABCD_00FF, 16'hAB10, 1'b0, 16'h000F, 16'h000F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
